// File: rtl/brp_update_sched_pkg.sv
// Shared types for the PHT maintenance-port scheduler: counter type, queued
// update record, FSM encoding and the 2-bit saturating counter step.
package brp_update_sched_pkg;

  typedef logic [1:0] brp_ctr_t;

  localparam brp_ctr_t BRP_CTR_MAX = 2'b11;
  localparam brp_ctr_t BRP_CTR_MIN = 2'b00;

  // Wide enough for any PHT size we expect to build; the top narrows it.
  localparam int BRP_IDX_MAX_W = 16;

  typedef struct packed {
    logic [BRP_IDX_MAX_W-1:0] idx;
    logic                     taken;
  } brp_upd_t;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WR
  } brp_state_t;

  function automatic brp_ctr_t brp_ctr_step(input brp_ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == BRP_CTR_MAX) ? BRP_CTR_MAX : brp_ctr_t'(ctr + 2'd1);
    end
    return (ctr == BRP_CTR_MIN) ? BRP_CTR_MIN : brp_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/brp_upd_fifo.sv
// Pending branch-resolution update queue. Flush empties it and wins over a
// simultaneous push; single flags exactly one entry left.
module brp_upd_fifo
  import brp_update_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  brp_upd_t push_data,
  input  logic     pop,
  input  logic     flush,
  output logic     full,
  output logic     empty,
  output logic     single,
  output brp_upd_t head
);

  localparam int PW = $clog2(DEPTH);

  brp_upd_t        mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign single  = (count == (PW+1)'(1));
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/brp_update_sched.sv
// Owner of the PHT maintenance port: init sweep, queued EX updates as
// read-modify-write pairs, and accepted/correct prediction statistics.
//
// state   | meaning
// INIT    | sweeping INIT_VAL into every counter (first cycle after reset is setup)
// IDLE    | sweep done, nothing queued
// RD      | reading counter at queue head
// WR      | writing stepped counter back, popping the head
module brp_update_sched
  import brp_update_sched_pkg::*;
#(
  parameter int          PHT_ENTRIES = 256,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [1:0]  INIT_VAL    = 2'b01,
  localparam int         IDX_W       = $clog2(PHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  input  logic             clear_req,
  output logic             init_done,
  output logic             pht_rd_en,
  output logic [IDX_W-1:0] pht_rd_idx,
  input  logic [1:0]       pht_rd_data,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_wr_idx,
  output logic [1:0]       pht_wr_data,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_correct
);

  brp_state_t       state;
  logic [IDX_W-1:0] sweep_idx;
  logic [IDX_W-1:0] head_idx;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_single;
  brp_upd_t         push_data;
  brp_upd_t         head;

  assign upd_ready = ~fifo_full;
  assign push      = upd_valid & upd_ready;
  assign push_data = '{idx: BRP_IDX_MAX_W'(upd_idx), taken: upd_taken};
  assign head_idx  = IDX_W'(head.idx);

  brp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (state == ST_WR),
    .flush     (clear_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .single    (fifo_single),
    .head      (head)
  );

  // Read data only arrives in WR, so the write value cannot be registered.
  assign pht_rd_idx  = head_idx;
  assign pht_wr_idx  = (state == ST_WR) ? head_idx : sweep_idx;
  assign pht_wr_data = (state == ST_WR) ? brp_ctr_step(pht_rd_data, head.taken) : INIT_VAL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      pht_we    <= 1'b0;
      pht_rd_en <= 1'b0;
      init_done <= 1'b0;
    end else if (clear_req) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      pht_we    <= 1'b1;
      pht_rd_en <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (!pht_we) begin
            pht_we <= 1'b1;
          end else if (sweep_idx == IDX_W'(PHT_ENTRIES - 1)) begin
            state     <= ST_IDLE;
            pht_we    <= 1'b0;
            init_done <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (!fifo_empty || push) begin
            state     <= ST_RD;
            pht_rd_en <= 1'b1;
          end
        end
        ST_RD: begin
          state     <= ST_WR;
          pht_rd_en <= 1'b0;
          pht_we    <= 1'b1;
        end
        ST_WR: begin
          pht_we <= 1'b0;
          if (!fifo_single || push) begin
            state     <= ST_RD;
            pht_rd_en <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_INIT;
          sweep_idx <= '0;
          pht_we    <= 1'b0;
          pht_rd_en <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (push) begin
      if (stat_total != '1) stat_total <= stat_total + 32'd1;
      if (!upd_mispredict && stat_correct != '1) stat_correct <= stat_correct + 32'd1;
    end
  end

endmodule

// File: tb/tb_brp_update_sched.sv
// Directed bench for brp_update_sched: sweep, RMW vector table, clear in RD,
// queueing during INIT and drain order.
module tb_brp_update_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_idx;
  logic       upd_taken;
  logic       upd_mispredict;
  logic       clear_req;
  logic       init_done;
  logic       pht_rd_en;
  logic [7:0] pht_rd_idx;
  logic [1:0] pht_rd_data;
  logic       pht_we;
  logic [7:0] pht_wr_idx;
  logic [1:0] pht_wr_data;
  logic [31:0] stat_total;
  logic [31:0] stat_correct;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brp_update_sched #(.PHT_ENTRIES(256), .FIFO_DEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .clear_req      (clear_req),
    .init_done      (init_done),
    .pht_rd_en      (pht_rd_en),
    .pht_rd_idx     (pht_rd_idx),
    .pht_rd_data    (pht_rd_data),
    .pht_we         (pht_we),
    .pht_wr_idx     (pht_wr_idx),
    .pht_wr_data    (pht_wr_data),
    .stat_total     (stat_total),
    .stat_correct   (stat_correct)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watches a full sweep; optionally opens it with clear_req and queues
  // push_n updates (idx 20..) starting on the second edge, plus one extra
  // attempt that must find the queue full.
  task automatic sweep_watch(input int push_n, input logic first_clear,
                             output int we_cnt, output int idx_err,
                             output int rd_cnt, output int done_cyc);
    we_cnt = 0; idx_err = 0; rd_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      clear_req = first_clear && (k == 1);
      upd_valid = 1'b0;
      if (push_n > 0 && k >= 2 && k <= push_n + 2) begin
        upd_valid      = 1'b1;
        upd_idx        = 8'(20 + k - 2);
        upd_taken      = ((k - 2) % 2 == 0);
        upd_mispredict = 1'b0;
        chk($sformatf("init_push%0d_ready", k - 1), 32'(upd_ready), 32'(k <= push_n + 1));
      end
      tick();
      if (pht_we) begin
        if (pht_wr_idx != 8'(we_cnt) || pht_wr_data != 2'b01) idx_err++;
        we_cnt++;
      end
      if (pht_rd_en) rd_cnt++;
      if (init_done) begin
        done_cyc = k;
        break;
      end
    end
    clear_req = 1'b0;
    upd_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] idx;
    logic       taken;
    logic       mp;
    logic [1:0] pre;
    logic [1:0] exp_wr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int we_cnt, idx_err, rd_cnt, done_cyc;
    int exp_tot, exp_cor;

    vecs[0] = '{8'd5,   1'b1, 1'b0, 2'b01, 2'b10};
    vecs[1] = '{8'd7,   1'b1, 1'b0, 2'b11, 2'b11};
    vecs[2] = '{8'd9,   1'b0, 1'b1, 2'b00, 2'b00};
    vecs[3] = '{8'd200, 1'b0, 1'b0, 2'b10, 2'b01};
    vecs[4] = '{8'd255, 1'b1, 1'b1, 2'b10, 2'b11};
    vecs[5] = '{8'd0,   1'b0, 1'b0, 2'b11, 2'b10};

    rst = 1'b0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    clear_req = 1'b0; pht_rd_data = 2'b01;
    exp_tot = 0; exp_cor = 0;

    repeat (3) @(negedge clk);
    chk("rst_we", 32'(pht_we), 0);
    chk("rst_rd_en", 32'(pht_rd_en), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_stat_total", stat_total, 0);
    chk("rst_stat_correct", stat_correct, 0);
    chk("rst_ready", 32'(upd_ready), 1);
    rst = 1'b1;

    sweep_watch(0, 1'b0, we_cnt, idx_err, rd_cnt, done_cyc);
    chk("sweep_we_cycles", we_cnt, 256);
    chk("sweep_idx_errors", idx_err, 0);
    chk("sweep_rd_en_cycles", rd_cnt, 0);
    chk("sweep_done_cycle", done_cyc, 257);
    chk("idle_we", 32'(pht_we), 0);
    chk("idle_ready", 32'(upd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      pht_rd_data    = vecs[i].pre;
      upd_valid      = 1'b1;
      upd_idx        = vecs[i].idx;
      upd_taken      = vecs[i].taken;
      upd_mispredict = vecs[i].mp;
      tick();
      upd_valid = 1'b0;
      exp_tot++;
      if (!vecs[i].mp) exp_cor++;
      chk($sformatf("v%0d_rd_en", i), 32'(pht_rd_en), 1);
      chk($sformatf("v%0d_rd_idx", i), 32'(pht_rd_idx), 32'(vecs[i].idx));
      chk($sformatf("v%0d_rd_we", i), 32'(pht_we), 0);
      tick();
      chk($sformatf("v%0d_we", i), 32'(pht_we), 1);
      chk($sformatf("v%0d_wr_rd_en", i), 32'(pht_rd_en), 0);
      chk($sformatf("v%0d_wr_idx", i), 32'(pht_wr_idx), 32'(vecs[i].idx));
      chk($sformatf("v%0d_wr_data", i), 32'(pht_wr_data), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_stat_total", i), stat_total, exp_tot);
      chk($sformatf("v%0d_stat_correct", i), stat_correct, exp_cor);
      tick();
      chk($sformatf("v%0d_idle_we", i), 32'(pht_we), 0);
      chk($sformatf("v%0d_idle_rd_en", i), 32'(pht_rd_en), 0);
    end

    // Three updates (mispredict 0,1,0), then clear while B is in RD with C queued.
    pht_rd_data = 2'b01;
    upd_valid = 1'b1; upd_idx = 8'd10; upd_taken = 1'b1; upd_mispredict = 1'b0;
    tick();
    exp_tot++; exp_cor++;
    chk("clr_a_rd_idx", 32'(pht_rd_idx), 10);
    upd_idx = 8'd11; upd_taken = 1'b0; upd_mispredict = 1'b1;
    tick();
    exp_tot++;
    chk("clr_a_we", 32'(pht_we), 1);
    chk("clr_a_wr_data", 32'(pht_wr_data), 32'(2'b10));
    upd_idx = 8'd12; upd_taken = 1'b1; upd_mispredict = 1'b0;
    tick();
    exp_tot++; exp_cor++;
    upd_valid = 1'b0;
    chk("clr_b_rd_en", 32'(pht_rd_en), 1);
    chk("clr_b_rd_idx", 32'(pht_rd_idx), 11);
    chk("clr_rd_no_write", 32'(pht_we), 0);
    chk("clr_pre_total", stat_total, exp_tot);
    chk("clr_pre_correct", stat_correct, exp_cor);

    sweep_watch(4, 1'b1, we_cnt, idx_err, rd_cnt, done_cyc);
    exp_tot += 4; exp_cor += 4;
    chk("clr_sweep_we_cycles", we_cnt, 256);
    chk("clr_sweep_idx_errors", idx_err, 0);
    chk("clr_sweep_rd_en_cycles", rd_cnt, 0);
    chk("clr_sweep_done_cycle", done_cyc, 257);
    chk("clr_post_total", stat_total, exp_tot);
    chk("clr_post_correct", stat_correct, exp_cor);
    chk("full_idle_ready", 32'(upd_ready), 0);

    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("drain%0d_rd_en", j), 32'(pht_rd_en), 1);
      chk($sformatf("drain%0d_rd_idx", j), 32'(pht_rd_idx), 32'(20 + j));
      chk($sformatf("drain%0d_rd_we", j), 32'(pht_we), 0);
      if (j == 1) chk("drain_ready_after_pop", 32'(upd_ready), 1);
      tick();
      chk($sformatf("drain%0d_we", j), 32'(pht_we), 1);
      chk($sformatf("drain%0d_wr_idx", j), 32'(pht_wr_idx), 32'(20 + j));
      chk($sformatf("drain%0d_wr_data", j), 32'(pht_wr_data), (j % 2 == 0) ? 32'd2 : 32'd0);
      if (j == 0) chk("drain_ready_in_full_pop", 32'(upd_ready), 0);
    end
    tick();
    chk("drain_end_rd_en", 32'(pht_rd_en), 0);
    chk("drain_end_we", 32'(pht_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
